// File: rtl/icap_reboot_sequencer_if.sv
// ICAP port bundle for the multiboot sequencer.
// master drives ce_b/write_b/din and samples busy.
interface icap_reboot_sequencer_if;
  logic        icap_ce_b;
  logic        icap_write_b;
  logic [15:0] icap_din;
  logic        icap_busy;

  modport master (
    output icap_ce_b,
    output icap_write_b,
    output icap_din,
    input  icap_busy
  );

  modport slave (
    input  icap_ce_b,
    input  icap_write_b,
    input  icap_din,
    output icap_busy
  );
endinterface

// File: rtl/icap_reboot_sequencer.sv
// Arbitrates SW / DIP reboot requests and streams the ICAP IPROG words.
// Ports: fastclk, rst_b, sw_req/sw_design, dip_in/dip_ref, init_done,
// icap (master), busy, hw_src, design_num. Option: ICAP_GOLDEN_EN.
module icap_reboot_sequencer #(
  parameter logic [23:0] BASE_ADDR   = 24'h000000,
  parameter logic [23:0] STRIDE      = 24'h060000,
  parameter logic [23:0] GOLDEN_ADDR = 24'h000000,
  parameter int          DEBOUNCE_W  = 16
) (
  input  logic        fastclk,
  input  logic        rst_b,
  input  logic        sw_req,
  input  logic [4:0]  sw_design,
  input  logic [3:0]  dip_in,
  input  logic [3:0]  dip_ref,
  input  logic        init_done,
  icap_reboot_sequencer_if.master icap,
  output logic        busy,
  output logic        hw_src,
  output logic [4:0]  design_num
);

`ifdef ICAP_GOLDEN_EN
  localparam logic [3:0] LAST = 4'd14;
`else
  localparam logic [3:0] LAST = 4'd10;
`endif

  typedef enum logic [1:0] {
    IDLE, CALC, SEND, DONE
  } state_t;

  state_t                st_q, st_d;
  logic [3:0]            s1_q, s2_q;
  logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
  logic                  hwp_q, hwp_d;
  logic                  swp_q, swp_d;
  logic [4:0]            swd_q, swd_d;
  logic [4:0]            dn_q, dn_d;
  logic                  hs_q, hs_d;
  logic [23:0]           addr_q, addr_d;
  logic [3:0]            idx_q, idx_d;
  logic [15:0]           din_q, din_d;
  logic                  ce_q, ce_d;
  logic                  wr_q, wr_d;

  function automatic logic [15:0] bswap(
    input logic [15:0] w
  );
    logic [15:0] o;
    for (int i = 0; i < 8; i++) begin
      o[i]    = w[7-i];
      o[15-i] = w[8+i];
    end
    return o;
  endfunction

  function automatic logic [15:0] raw_word(
    input logic [3:0]  i,
    input logic [23:0] a
  );
    logic [15:0] w;
    case (i)
      4'd0:    w = 16'hFFFF;
      4'd1:    w = 16'hAA99;
      4'd2:    w = 16'h5566;
      4'd3:    w = 16'h3261;
      4'd4:    w = a[15:0];
      4'd5:    w = 16'h3281;
      4'd6:    w = {8'h03, a[23:16]};
`ifdef ICAP_GOLDEN_EN
      4'd7:    w = 16'h32A1;
      4'd8:    w = GOLDEN_ADDR[15:0];
      4'd9:    w = 16'h32C1;
      4'd10:   w = {8'h03, GOLDEN_ADDR[23:16]};
      4'd11:   w = 16'h30A1;
      4'd12:   w = 16'h000E;
`else
      4'd7:    w = 16'h30A1;
      4'd8:    w = 16'h000E;
`endif
      default: w = 16'h2000;
    endcase
    return w;
  endfunction

  always_ff @(posedge fastclk or negedge rst_b) begin
    if (!rst_b) begin
      st_q   <= IDLE;
      s1_q   <= '0;
      s2_q   <= '0;
      cnt_q  <= '0;
      hwp_q  <= 1'b0;
      swp_q  <= 1'b0;
      swd_q  <= '0;
      dn_q   <= '0;
      hs_q   <= 1'b0;
      addr_q <= '0;
      idx_q  <= '0;
      din_q  <= 16'hFFFF;
      ce_q   <= 1'b1;
      wr_q   <= 1'b1;
    end else begin
      st_q   <= st_d;
      s1_q   <= dip_in;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      hwp_q  <= hwp_d;
      swp_q  <= swp_d;
      swd_q  <= swd_d;
      dn_q   <= dn_d;
      hs_q   <= hs_d;
      addr_q <= addr_d;
      idx_q  <= idx_d;
      din_q  <= din_d;
      ce_q   <= ce_d;
      wr_q   <= wr_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    hwp_d  = hwp_q;
    swp_d  = swp_q | sw_req;
    swd_d  = sw_req ? sw_design : swd_q;
    dn_d   = dn_q;
    hs_d   = hs_q;
    addr_d = addr_q;
    idx_d  = idx_q;
    din_d  = din_q;
    ce_d   = ce_q;
    wr_d   = wr_q;

    // Counter saturates at all-ones; the flag stays up until accepted.
    if (!init_done || s2_q == dip_ref) begin
      cnt_d = '0;
    end else if (!(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (init_done && (&cnt_q)) begin
      hwp_d = 1'b1;
    end

    case (st_q)
      IDLE: begin
        if (init_done && hwp_q) begin
          hwp_d = 1'b0;
          dn_d  = 5'b10000;
          hs_d  = 1'b1;
          wr_d  = 1'b0;
          st_d  = CALC;
        end else if (init_done && swp_q) begin
          swp_d = 1'b0;
          dn_d  = swd_q;
          hs_d  = 1'b0;
          wr_d  = 1'b0;
          st_d  = CALC;
        end
      end
      CALC: begin
        addr_d = BASE_ADDR + STRIDE * {19'd0, dn_q};
        idx_d  = 4'd0;
        din_d  = bswap(raw_word(4'd0, addr_d));
        ce_d   = 1'b0;
        st_d   = SEND;
      end
      SEND: begin
        if (!icap.icap_busy) begin
          if (idx_q == LAST) begin
            ce_d = 1'b1;
            st_d = DONE;
          end else begin
            idx_d = idx_q + 4'd1;
            din_d = bswap(raw_word(idx_d, addr_q));
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign icap.icap_ce_b    = ce_q;
  assign icap.icap_write_b = wr_q;
  assign icap.icap_din     = din_q;
  assign busy              = (st_q != IDLE);
  assign hw_src            = hs_q;
  assign design_num        = dn_q;

endmodule
